// File: rtl/muldiv_sequencer.sv
// HI/LO owner for the MIPS core: fixed-latency mult/div sequencer with
// mthi/mtlo writes, E-stage stall generation and M-stage cancel/undo.
module muldiv_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_E,
  input  logic [2:0]  op_E,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hilo_use_E,
  input  logic        cancel_M,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] shadow_hi_q, shadow_hi_d, shadow_lo_q, shadow_lo_d;
  logic        undo_q, undo_d;
  logic        fresh_q, fresh_d;

  // Low 64 bits of a 64x64 product are the same for either signedness, so
  // sign- or zero-extending the operands gives mult and multu from one multiply.
  function automatic logic [63:0] mul_calc(input logic is_signed,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] ea, eb;
    ea = {{32{is_signed & a[31]}}, a};
    eb = {{32{is_signed & b[31]}}, b};
    return ea * eb;
  endfunction

  // Magnitude division avoids the 0x80000000 / -1 overflow corner; returns {rem, quo}.
  function automatic logic [63:0] div_calc(input logic is_signed,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic        neg_a, neg_b;
    logic [31:0] ma, mb, q, r;
    neg_a = is_signed & a[31];
    neg_b = is_signed & b[31];
    ma    = neg_a ? -a : a;
    mb    = neg_b ? -b : b;
    if (mb == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    return {(neg_a ? -r : r), ((neg_a ^ neg_b) ? -q : q)};
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    shadow_hi_d = shadow_hi_q;
    shadow_lo_d = shadow_lo_q;
    undo_d      = 1'b0;
    fresh_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // The younger instruction in E is flushed along with the faulting mthi/mtlo.
        if (undo_q && cancel_M) begin
          hi_d = shadow_hi_q;
          lo_d = shadow_lo_q;
        end else if (start_E) begin
          case (op_E)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              a_d         = src_a;
              b_d         = src_b;
              op_d        = op_E;
              cnt_d       = (op_E == OP_MULT || op_E == OP_MULTU) ? MULT_LOAD : DIV_LOAD;
              shadow_hi_d = hi_q;
              shadow_lo_d = lo_q;
              fresh_d     = 1'b1;
              state_d     = RUN;
            end
            OP_MTHI: begin
              shadow_hi_d = hi_q;
              shadow_lo_d = lo_q;
              hi_d        = src_a;
              undo_d      = 1'b1;
            end
            OP_MTLO: begin
              shadow_hi_d = hi_q;
              shadow_lo_d = lo_q;
              lo_d        = src_a;
              undo_d      = 1'b1;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        if (fresh_q && cancel_M) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
          if (op_q == OP_MULT || op_q == OP_MULTU) begin
            {hi_d, lo_d} = mul_calc(op_q == OP_MULT, a_q, b_q);
          end else if (b_q != 32'd0) begin
            {hi_d, lo_d} = div_calc(op_q == OP_DIV, a_q, b_q);
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      op_q        <= 3'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      shadow_hi_q <= 32'd0;
      shadow_lo_q <= 32'd0;
      undo_q      <= 1'b0;
      fresh_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      shadow_hi_q <= shadow_hi_d;
      shadow_lo_q <= shadow_lo_d;
      undo_q      <= undo_d;
      fresh_q     <= fresh_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign stall = hilo_use_E & busy;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, results, cancel/undo, stall, async reset.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_E;
  logic [2:0]  op_E;
  logic [31:0] src_a, src_b;
  logic        hilo_use_E;
  logic        cancel_M;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;
  int bc;

  muldiv_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start_E(start_E), .op_E(op_E),
    .src_a(src_a), .src_b(src_b), .hilo_use_E(hilo_use_E),
    .cancel_M(cancel_M), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Pipeline stall must keep any HI/LO start away while busy.
  always @(posedge clk) begin
    if (!reset) assert (!(start_E && busy)) else $error("start_E accepted while busy");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue op at the next edge, then count busy cycles (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    start_E = 1'b1; op_E = op; src_a = a; src_b = b;
    tick;
    start_E = 1'b0; op_E = 3'd0;
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      tick;
    end
  endtask

  initial begin
    reset = 1'b1; start_E = 1'b0; op_E = 3'd0; src_a = '0; src_b = '0;
    hilo_use_E = 1'b1; cancel_M = 1'b0;
    tick; tick;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    reset = 1'b0; hilo_use_E = 1'b0;
    tick;

    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, bc);
    chk("mult_busy", bc, 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, bc);
    chk("multu_busy", bc, 32'd5);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, bc);
    chk("div_busy", bc, 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    run_op(3'd4, 32'd7, 32'd0, bc);
    chk("divu0_busy", bc, 32'd10);
    chk("divu0_lo", lo, 32'hFFFF_FFFD);
    chk("divu0_hi", hi, 32'hFFFF_FFFF);

    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, bc);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0);

    // mthi then cancel in the following cycle: HI reverts
    start_E = 1'b1; op_E = 3'd5; src_a = 32'h1234;
    tick;
    start_E = 1'b0; op_E = 3'd0;
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    cancel_M = 1'b1;
    tick;
    cancel_M = 1'b0;
    chk("mthi_undo_hi", hi, 32'h0);
    chk("mthi_undo_lo", lo, 32'h8000_0000);

    start_E = 1'b1; op_E = 3'd6; src_a = 32'h55;
    tick;
    start_E = 1'b0; op_E = 3'd0;
    chk("mtlo_lo", lo, 32'h55);
    tick;
    cancel_M = 1'b1;
    tick;
    cancel_M = 1'b0;
    chk("mtlo_late_cancel_lo", lo, 32'h55);

    // mult followed by mflo: stall in busy cycles 2..5
    start_E = 1'b1; op_E = 3'd1; src_a = 32'd7; src_b = 32'd6;
    tick;
    start_E = 1'b0; op_E = 3'd0;
    chk("stall_c1", {31'd0, stall}, 32'd0);
    tick;
    hilo_use_E = 1'b1;
    for (int c = 2; c <= 5; c++) begin
      #1;
      chk($sformatf("stall_c%0d", c), {31'd0, stall}, 32'd1);
      tick;
    end
    #1;
    chk("stall_c6", {31'd0, stall}, 32'd0);
    chk("stall_lo", lo, 32'd42);
    chk("stall_hi", hi, 32'd0);
    hilo_use_E = 1'b0;

    // div cancelled in the first busy cycle
    start_E = 1'b1; op_E = 3'd3; src_a = 32'd100; src_b = 32'd7;
    tick;
    start_E = 1'b0; op_E = 3'd0;
    chk("dcan_busy1", {31'd0, busy}, 32'd1);
    cancel_M = 1'b1;
    tick;
    cancel_M = 1'b0;
    chk("dcan_busy2", {31'd0, busy}, 32'd0);
    tick; tick;
    chk("dcan_lo", lo, 32'd42);
    chk("dcan_hi", hi, 32'd0);

    // cancel in busy cycle 3 is ignored
    start_E = 1'b1; op_E = 3'd3; src_a = 32'd100; src_b = 32'd7;
    tick;
    start_E = 1'b0; op_E = 3'd0;
    tick; tick;
    cancel_M = 1'b1;
    tick;
    cancel_M = 1'b0;
    bc = 3;
    while (busy && bc < 40) begin
      bc++;
      tick;
    end
    chk("dlate_busy", bc, 32'd10);
    chk("dlate_lo", lo, 32'd14);
    chk("dlate_hi", hi, 32'd2);

    // async reset in busy cycle 3 of a div
    start_E = 1'b1; op_E = 3'd3; src_a = 32'd100; src_b = 32'd3;
    tick;
    start_E = 1'b0; op_E = 3'd0;
    tick; tick;
    #2 reset = 1'b1;
    #1;
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    #2 reset = 1'b0;
    tick;
    run_op(3'd1, 32'd5, 32'hFFFF_FFFD, bc);
    chk("post_busy", bc, 32'd5);
    chk("post_hi", hi, 32'hFFFF_FFFF);
    chk("post_lo", lo, 32'hFFFF_FFF1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS core. Sits beside the E-stage ALU. It accepts mult/multu/div/divu/mthi/mtlo from E and models fixed multi-cycle latency with a countdown FSM. It raises a stall for any HI/LO-using instruction in E while busy, and undoes or aborts an operation whose instruction faults in M (exception/interrupt via CP0).

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Clock and reset: one clock; reset is asynchronous and active-high.

- clk  in  1  clock
- reset  in  1  asynchronous, active-high; clears all state
- start_E  in  1  E-stage HI/LO-writing instruction is valid and not stalled this cycle
- op_E  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo (7 treated as none)
- src_a  in  32  rs value (dividend / multiplicand / mthi-mtlo data)
- src_b  in  32  rt value (divisor / multiplier)
- hilo_use_E  in  1  instruction in E is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- cancel_M  in  1  instruction now in M is being flushed by exception/interrupt
- busy  out  1  multi-cycle operation in progress
- stall  out  1  hilo_use_E & busy (combinational)
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- FSM states: IDLE, RUN.
- IDLE + start_E with op 1-4:
  - latch src_a/src_b and the op
  - load counter with MULT_CYCLES or DIV_CYCLES
  - snapshot hi/lo into shadow
  - go to RUN
- IDLE + start_E with op 5/6:
  - snapshot hi/lo into shadow
  - write hi (op 5) or lo (op 6) from src_a at the same edge
  - stay IDLE
  - arm a one-cycle "undo" flag
- RUN:
  - counter decrements each edge
  - at the edge where counter==1: write result to hi/lo and go to IDLE
- Results:
  - mult/multu: {hi,lo} = 64-bit signed/unsigned product.
  - div/divu: lo = quotient, hi = remainder. Signed division truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 div 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - Divisor 0 (div or divu): hi/lo unchanged on completion; busy timing identical.
- Cancel: cancel_M is honored only in the cycle immediately after a start edge.
  - If RUN: return to IDLE at next edge; hi/lo untouched.
  - If undo flag set (mthi/mtlo): restore hi/lo from shadow at next edge.
  - cancel_M at any other time is ignored.
- start_E while busy: ignored; stall must already be blocking it. A bench assertion flags it.
- Reset mid-operation: abort immediately, no result written.

## Timing
- Reset values: hi=0, lo=0, busy=0, stall=0, state IDLE, counter=0, undo flag=0.
- mult started at edge k: busy=1 in cycles k+1..k+MULT_CYCLES; hi/lo show the result from cycle k+MULT_CYCLES+1; busy=0 that same cycle.
- div: same, with DIV_CYCLES.
- mthi/mtlo at edge k: new value visible in cycle k+1; busy never asserts.
- Back-to-back: a new start is accepted in the first cycle busy=0.
- stall has zero latency from hilo_use_E/busy. mfhi/mflo in E reads hi/lo in the cycle stall drops.
- Cancel in cycle k+1: busy=0 and original hi/lo from cycle k+2.

## Test plan
- mult 0xFFFFFFFE × 3 (signed): busy exactly 5 cycles -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with multu -> hi=0x2, lo=0xFFFFFFFA.
- div -7 / 2: busy 10 cycles -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu 7/0 -> hi/lo unchanged after 10 busy cycles.
- mthi 0x1234 with cancel_M in the next cycle -> hi reverts to prior value (e.g. 0). mtlo 0x55 without cancel -> lo=0x55 next cycle.
- mult start, then mflo in E with hilo_use_E=1 -> stall=1 for cycles 2..5 of busy; stall=0 and lo valid in cycle 6.
- div start, cancel_M next cycle -> busy=0 after one cycle, hi/lo unchanged. cancel_M in busy cycle 3 -> ignored, result written.
- Assert reset asynchronously at busy cycle 3 of a div -> hi=lo=0 and busy=0 immediately. First post-reset mult completes normally.
